// File: rtl/pcie_dllp_receiver.sv
// -----------------------------------------------------------------------------
// pcie_dllp_receiver
//
// Purpose : Extracts PCIe Data Link Layer Packets from a 2-symbol-per-clock
//           8b/10b-decoded receive stream. Frames SDP .. 4 DLLP bytes ..
//           2 CRC bytes .. END, checks the DLLP CRC-16, and reports either a
//           good DLLP (type + 24-bit payload) or a discarded one.
//
// Ports   : clk                  - sole clock, rising edge
//           rst                  - asynchronous active-high reset
//           rx_data_i[15:0]      - two symbols; [7:0] earlier, [15:8] later
//           rx_charisk_i[1:0]    - K-character flag per byte (bit0 = [7:0])
//           rx_err_i[1:0]        - decode/disparity error per byte
//           rx_dllp_valid_o      - one-cycle pulse, good DLLP delivered
//           rx_dllp_type_o[7:0]  - DLLP byte 0, held until next good DLLP
//           rx_dllp_data_o[23:0] - DLLP bytes 1..3 (byte 1 in [23:16]), held
//           rx_dllp_bad_o        - one-cycle pulse, DLLP discarded
//           rx_dllp_bad_count_o  - saturating discard counter (only when
//                                  PCIE_DLLP_RX_STATS_EN is defined)
//
// Build option: define PCIE_DLLP_RX_STATS_EN to add the discard counter port.
// -----------------------------------------------------------------------------
module pcie_dllp_receiver (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_charisk_i,
    input  logic [1:0]  rx_err_i,
    output logic        rx_dllp_valid_o,
    output logic [7:0]  rx_dllp_type_o,
    output logic [23:0] rx_dllp_data_o,
    output logic        rx_dllp_bad_o
`ifdef PCIE_DLLP_RX_STATS_EN
    ,
    output logic [15:0] rx_dllp_bad_count_o
`endif
);

    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;

    typedef enum logic {IDLE, BODY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] body_q, body_d;      // DLLP bytes 0..3, byte 0 in [31:24]
    logic [15:0] crc_rx_q, crc_rx_d;  // received CRC, byte 4 in [15:8]
    logic        good_d, bad_d;
    logic [31:0] good_body_d;

    logic        rx_dllp_valid_q, rx_dllp_bad_q;
    logic [7:0]  rx_dllp_type_q;
    logic [23:0] rx_dllp_data_q;

    logic [7:0]  lane_byte;
    logic        lane_k, lane_err, lane_sdp, lane_abort;

    // DLLP CRC-16 (poly 0x100B, seed 0xFFFF). Each byte enters bit 0 first;
    // the remainder is complemented and fully bit-reversed so that the
    // result's [15:8] is the first transmitted CRC byte.
    function automatic logic [15:0] dllp_crc(input logic [31:0] d);
        logic [15:0] r;
        logic [15:0] c;
        logic [15:0] o;
        logic        fb;
        r = 16'hFFFF;
        for (int bi = 0; bi < 4; bi++) begin
            for (int ti = 0; ti < 8; ti++) begin
                fb = r[15] ^ d[24 - 8*bi + ti];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h100B;
            end
        end
        c = ~r;
        for (int ki = 0; ki < 16; ki++) o[ki] = c[15 - ki];
        return o;
    endfunction

    // Walk both byte lanes in order, carrying the framing state from lane 0
    // into lane 1 so that SDP/END may fall in either lane.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        body_d      = body_q;
        crc_rx_d    = crc_rx_q;
        good_d      = 1'b0;
        bad_d       = 1'b0;
        good_body_d = {rx_dllp_type_q, rx_dllp_data_q};
        lane_byte   = 8'h00;
        lane_k      = 1'b0;
        lane_err    = 1'b0;
        lane_sdp    = 1'b0;
        lane_abort  = 1'b0;
        for (int li = 0; li < 2; li++) begin
            lane_byte  = rx_data_i[li*8 +: 8];
            lane_k     = rx_charisk_i[li];
            lane_err   = rx_err_i[li];
            lane_sdp   = lane_k && (lane_byte == SYM_SDP);
            lane_abort = 1'b0;
            if (state_d == IDLE) begin
                if (lane_sdp) begin
                    state_d = BODY;
                    idx_d   = 3'd0;
                end
            end else begin
                lane_abort = lane_err
                           || ((idx_d != 3'd6) && lane_k)
                           || ((idx_d == 3'd6) && !(lane_k && (lane_byte == SYM_END)));
                if (lane_abort) begin
                    // Two aborts in one cycle collapse into a single bad pulse.
                    bad_d = 1'b1;
                    idx_d = 3'd0;
                    if (!lane_sdp) state_d = IDLE;
                end else if (idx_d == 3'd6) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    if (dllp_crc(body_d) == crc_rx_d) begin
                        good_d      = 1'b1;
                        good_body_d = body_d;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else begin
                    case (idx_d)
                        3'd0:    body_d[31:24]  = lane_byte;
                        3'd1:    body_d[23:16]  = lane_byte;
                        3'd2:    body_d[15:8]   = lane_byte;
                        3'd3:    body_d[7:0]    = lane_byte;
                        3'd4:    crc_rx_d[15:8] = lane_byte;
                        default: crc_rx_d[7:0]  = lane_byte;
                    endcase
                    idx_d = idx_d + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= 3'd0;
            body_q          <= 32'h0;
            crc_rx_q        <= 16'h0;
            rx_dllp_valid_q <= 1'b0;
            rx_dllp_bad_q   <= 1'b0;
            rx_dllp_type_q  <= 8'h00;
            rx_dllp_data_q  <= 24'h0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            body_q          <= body_d;
            crc_rx_q        <= crc_rx_d;
            rx_dllp_valid_q <= good_d;
            // A good completion is never followed by an abort in the same
            // cycle, but the mask keeps the two pulses exclusive by design.
            rx_dllp_bad_q   <= bad_d & ~good_d;
            if (good_d) begin
                rx_dllp_type_q <= good_body_d[31:24];
                rx_dllp_data_q <= good_body_d[23:0];
            end
        end
    end

`ifdef PCIE_DLLP_RX_STATS_EN
    logic [15:0] bad_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_count_q <= 16'h0;
        end else if (bad_d && !good_d && (bad_count_q != 16'hFFFF)) begin
            bad_count_q <= bad_count_q + 16'd1;
        end
    end

    assign rx_dllp_bad_count_o = bad_count_q;
`endif

    assign rx_dllp_valid_o = rx_dllp_valid_q;
    assign rx_dllp_bad_o   = rx_dllp_bad_q;
    assign rx_dllp_type_o  = rx_dllp_type_q;
    assign rx_dllp_data_o  = rx_dllp_data_q;

endmodule

// File: tb/tb_pcie_dllp_receiver.sv
// -----------------------------------------------------------------------------
// tb_pcie_dllp_receiver
//
// Purpose : Self-checking bench for pcie_dllp_receiver. Symbols are queued,
//           packed two per clock, and every symbol that should produce a
//           result pushes its expected outcome (kind, type/data, edge number)
//           onto a scoreboard. A monitor records every observed pulse; each
//           test task compares the two queues inline.
// Build option: PCIE_DLLP_RX_STATS_EN enables the discard counter checks.
// -----------------------------------------------------------------------------
module tb_pcie_dllp_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rx_data = 16'h0;
    logic [1:0]  rx_charisk = 2'b00;
    logic [1:0]  rx_err = 2'b00;
    logic        rx_dllp_valid;
    logic [7:0]  rx_dllp_type;
    logic [23:0] rx_dllp_data;
    logic        rx_dllp_bad;
`ifdef PCIE_DLLP_RX_STATS_EN
    logic [15:0] rx_dllp_bad_count;
`endif

    pcie_dllp_receiver dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_i       (rx_data),
        .rx_charisk_i    (rx_charisk),
        .rx_err_i        (rx_err),
        .rx_dllp_valid_o (rx_dllp_valid),
        .rx_dllp_type_o  (rx_dllp_type),
        .rx_dllp_data_o  (rx_dllp_data),
        .rx_dllp_bad_o   (rx_dllp_bad)
`ifdef PCIE_DLLP_RX_STATS_EN
        ,
        .rx_dllp_bad_count_o (rx_dllp_bad_count)
`endif
    );

    always #5 clk = ~clk;

    // kind: 2'b01 valid, 2'b10 bad
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] td;
        logic [31:0] edg;
    } res_t;

    typedef struct packed {
        logic [7:0]  b;
        logic        k;
        logic        e;
        logic [1:0]  tag;   // 0 none, 1 expect valid, 2 expect bad
        logic [31:0] td;
    } sym_t;

    sym_t        sym_q[$];
    res_t        exp_q[$];
    res_t        obs_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_td = 32'h0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst && (rx_dllp_valid || rx_dllp_bad))
            obs_q.push_back({rx_dllp_bad, rx_dllp_valid, rx_dllp_type, rx_dllp_data, cyc});
    end

    // Reflected form of the DLLP CRC: LSB-first shift with reversed poly.
    function automatic logic [15:0] crc_ref(input logic [31:0] d);
        logic [15:0] r;
        logic [7:0]  by;
        logic        fb;
        r = 16'hFFFF;
        for (int j = 0; j < 4; j++) begin
            by = d[31 - 8*j -: 8];
            for (int i = 0; i < 8; i++) begin
                fb = r[0] ^ by[i];
                r  = r >> 1;
                if (fb) r = r ^ 16'hD008;
            end
        end
        return ~r;
    endfunction

    task automatic push_sym(input logic [7:0] b, input logic k, input logic e,
                            input logic [1:0] tag, input logic [31:0] td);
        sym_q.push_back({b, k, e, tag, td});
    endtask

    task automatic push_dllp(input logic [7:0] t, input logic [23:0] d,
                             input logic [15:0] crc_x, input logic with_sdp);
        logic [31:0] body;
        logic [15:0] c;
        body = {t, d};
        c    = crc_ref(body) ^ crc_x;
        if (with_sdp) push_sym(8'h5C, 1'b1, 1'b0, 2'd0, 32'h0);
        for (int j = 0; j < 4; j++) push_sym(body[31 - 8*j -: 8], 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(c[15:8], 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(c[7:0],  1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'hFD, 1'b1, 1'b0, (crc_x == 16'h0) ? 2'd1 : 2'd2, body);
    endtask

    task automatic note(input sym_t s);
        if (s.tag == 2'd1) begin
            last_td = s.td;
            exp_q.push_back({2'b01, last_td, cyc + 32'd1});
        end else if (s.tag == 2'd2) begin
            exp_q.push_back({2'b10, last_td, cyc + 32'd1});
        end
    endtask

    task automatic drive_idle();
        rx_data    = 16'h0;
        rx_charisk = 2'b00;
        rx_err     = 2'b00;
    endtask

    task automatic flush();
        sym_t a, b2;
        while (sym_q.size() > 0) begin
            a = sym_q.pop_front();
            if (sym_q.size() > 0) b2 = sym_q.pop_front();
            else                  b2 = '0;
            @(negedge clk);
            rx_data    = {b2.b, a.b};
            rx_charisk = {b2.k, a.k};
            rx_err     = {b2.e, a.e};
            note(a);
            note(b2);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (rx_dllp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_dllp_valid); end
        total++; if (rx_dllp_bad !== 1'b0) begin bad++; $display("FAIL reset_bad got=%b exp=0", rx_dllp_bad); end
        total++; if (rx_dllp_type !== 8'h00) begin bad++; $display("FAIL reset_type got=%h exp=00", rx_dllp_type); end
        total++; if (rx_dllp_data !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=000000", rx_dllp_data); end
`ifdef PCIE_DLLP_RX_STATS_EN
        total++; if (rx_dllp_bad_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0000", rx_dllp_bad_count); end
`endif
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_ack_lane0();
        res_t o, e;
        push_dllp(8'h00, 24'h000005, 16'h0, 1'b1);
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            bad++; $display("FAIL ack_lane0_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ack_lane0 got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_ack_lane0: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_ack_lane1();
        res_t o, e;
        push_sym(8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
        push_dllp(8'h00, 24'h000005, 16'h0, 1'b1);
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            bad++; $display("FAIL ack_lane1_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ack_lane1 got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_ack_lane1: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_crc_bad();
        res_t o, e;
        push_dllp(8'h40, 24'h123456, 16'h0001, 1'b1);
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            bad++; $display("FAIL crc_bad_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL crc_bad got=%h exp=%h", o, e); end
        end
        total++;
        if ({rx_dllp_type, rx_dllp_data} !== 32'h00000005) begin
            bad++; $display("FAIL crc_bad_hold got=%h exp=00000005", {rx_dllp_type, rx_dllp_data});
        end
`ifdef PCIE_DLLP_RX_STATS_EN
        total++;
        if (rx_dllp_bad_count !== 16'd1) begin bad++; $display("FAIL crc_bad_cnt got=%0d exp=1", rx_dllp_bad_count); end
`endif
        obs_q.delete(); exp_q.delete();
        $display("test_crc_bad: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_err_abort();
        res_t o, e;
        push_sym(8'h5C, 1'b1, 1'b0, 2'd0, 32'h0);
        push_sym(8'h40, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h12, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h34, 1'b0, 1'b1, 2'd2, 32'h0);   // lands in lane 1
        push_dllp(8'h80, 24'hABCDEF, 16'h0, 1'b1);
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            bad++; $display("FAIL err_abort_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int n = 0; n < 2; n++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total++;
                if (o !== e) begin bad++; $display("FAIL err_abort_%0d got=%h exp=%h", n, o, e); end
            end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_err_abort: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_k_restart();
        res_t o, e;
        push_sym(8'h5C, 1'b1, 1'b0, 2'd0, 32'h0);
        push_sym(8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h5C, 1'b1, 1'b0, 2'd2, 32'h0);   // SDP mid-body: abort and restart
        push_dllp(8'h20, 24'h001122, 16'h0, 1'b0);
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            bad++; $display("FAIL k_restart_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int n = 0; n < 2; n++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total++;
                if (o !== e) begin bad++; $display("FAIL k_restart_%0d got=%h exp=%h", n, o, e); end
            end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_k_restart: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_framing();
        res_t o, e;
        logic [15:0] c;
        c = crc_ref(32'hA0010203);
        push_sym(8'h5C, 1'b1, 1'b0, 2'd0, 32'h0);
        push_sym(8'hA0, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h01, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h02, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h03, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(c[15:8], 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(c[7:0],  1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'hFD, 1'b0, 1'b0, 2'd2, 32'h0);   // END value but not a K char
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            bad++; $display("FAIL framing_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL framing got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_framing: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_back_to_back();
        res_t o0, o1, e;
        push_sym(8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
        push_dllp(8'h10, 24'h0000AA, 16'h0, 1'b1);  // END lands in lane 0
        push_dllp(8'h60, 24'h7788FF, 16'h0, 1'b1);  // SDP in lane 1, same cycle
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            o0 = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o0 !== e) begin bad++; $display("FAIL b2b_first got=%h exp=%h", o0, e); end
            o1 = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o1 !== e) begin bad++; $display("FAIL b2b_second got=%h exp=%h", o1, e); end
            total++;
            if (o1.edg - o0.edg !== 32'd4) begin bad++; $display("FAIL b2b_spacing got=%0d exp=4", o1.edg - o0.edg); end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_back_to_back: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

    task automatic test_reset_mid();
        res_t o, e;
        push_sym(8'h5C, 1'b1, 1'b0, 2'd0, 32'h0);
        push_sym(8'h40, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h11, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h22, 1'b0, 1'b0, 2'd0, 32'h0);
        flush();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({rx_dllp_valid, rx_dllp_bad, rx_dllp_type, rx_dllp_data} !== 34'h0) begin
            bad++; $display("FAIL reset_mid_outputs got=%h exp=0", {rx_dllp_valid, rx_dllp_bad, rx_dllp_type, rx_dllp_data});
        end
        // finish the interrupted DLLP's bytes while reset is held
        push_sym(8'h33, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
        push_sym(8'hFD, 1'b1, 1'b0, 2'd0, 32'h0);
        flush();
        last_td = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL reset_mid_pulse got=%0d exp=0", obs_q.size()); end
`ifdef PCIE_DLLP_RX_STATS_EN
        total++;
        if (rx_dllp_bad_count !== 16'h0) begin bad++; $display("FAIL reset_mid_cnt got=%h exp=0000", rx_dllp_bad_count); end
`endif
        // first SDP right after deassertion must be taken
        sym_q.delete();
        push_dllp(8'hC0, 24'h000123, 16'h0, 1'b1);
        begin
            sym_t a, b2;
            a = sym_q.pop_front(); b2 = sym_q.pop_front();
            rx_data = {b2.b, a.b}; rx_charisk = {b2.k, a.k}; rx_err = {b2.e, a.e};
        end
        flush();
        idle_cycles(3);
        total++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            bad++; $display("FAIL post_reset_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL post_reset got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
        $display("test_reset_mid: type=%h data=%h", rx_dllp_type, rx_dllp_data);
    endtask

`ifdef PCIE_DLLP_RX_STATS_EN
    task automatic test_saturation();
        // SDP then COM in one cycle: one discard per clock
        repeat (65537) begin
            @(negedge clk);
            rx_data = 16'hBC5C; rx_charisk = 2'b11; rx_err = 2'b00;
        end
        idle_cycles(3);
        total++;
        if (rx_dllp_bad_count !== 16'hFFFF) begin bad++; $display("FAIL saturation got=%h exp=FFFF", rx_dllp_bad_count); end
        obs_q.delete(); exp_q.delete();
        $display("test_saturation: count=%h", rx_dllp_bad_count);
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_ack_lane0();
        test_ack_lane1();
        test_crc_bad();
        test_err_abort();
        test_k_restart();
        test_framing();
        test_back_to_back();
        test_reset_mid();
`ifdef PCIE_DLLP_RX_STATS_EN
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
